// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into big-endian 32-bit words and
// appends 0x80, zero fill and the 64-bit bit length so whole 512-bit blocks leave.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   ACCEPT | taking message bytes, emitting each completed word
//   PAD    | emitting final (full or partial) word and the 0x80 marker word
//   ZERO   | emitting zero words until word index 14 is next
//   LEN_HI | emitting bit length [63:32]
//   LEN_LO | emitting bit length [31:0] with tlast, then clearing
module sha256_padder #(
  parameter int LEN_W = 32
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        s_axis_tvalid,
  input  logic [3:0]  s_axis_tkeep,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast
);

  typedef enum logic [2:0] {
    ACCEPT = 3'd0,
    PAD    = 3'd1,
    ZERO   = 3'd2,
    LEN_HI = 3'd3,
    LEN_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pack_q, pack_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               full_q, full_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               in_hs;
  logic               out_hs;
  logic [1:0]         lane;
  logic [7:0]         in_byte;
  logic [31:0]        merged;
  logic [31:0]        pad_mark;
  logic [3:0]         wcnt_inc;
  logic [63:0]        bit_len;
  logic               unused_inputs;

  assign unused_inputs = ^{s_axis_tkeep, s_axis_tdata[31:8]};

  assign s_axis_tready = (state_q == ACCEPT) && !valid_q && !m_axis_areset;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = valid_q && m_axis_tready;
  assign lane          = bcnt_q[1:0];
  assign in_byte       = s_axis_tdata[7:0];
  assign wcnt_inc      = wcnt_q + 4'd1;
  assign bit_len       = 64'(bcnt_q) << 3;

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tkeep  = valid_q ? 4'b1111 : 4'b0000;

  // Byte lane 0 is the most significant byte; pad_mark is the 0x80 just after it.
  always_comb begin
    merged   = pack_q;
    pad_mark = 32'h0000_0000;
    case (lane)
      2'd0: begin
        merged[31:24] = in_byte;
        pad_mark      = 32'h0080_0000;
      end
      2'd1: begin
        merged[23:16] = in_byte;
        pad_mark      = 32'h0000_8000;
      end
      2'd2: begin
        merged[15:8]  = in_byte;
        pad_mark      = 32'h0000_0080;
      end
      default: begin
        merged[7:0]   = in_byte;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pack_d  = pack_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    full_d  = full_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (out_hs) begin
      wcnt_d = wcnt_inc;
    end

    case (state_q)
      ACCEPT: begin
        if (out_hs) begin
          valid_d = 1'b0;
          data_d  = 32'h0000_0000;
        end
        if (in_hs) begin
          bcnt_d = bcnt_q + LEN_W'(1);
          if (lane == 2'd3) begin
            data_d  = merged;
            valid_d = 1'b1;
            pack_d  = 32'h0000_0000;
            if (s_axis_tlast) begin
              state_d = PAD;
              full_d  = 1'b1;
            end
          end else if (s_axis_tlast) begin
            data_d  = merged | pad_mark;
            valid_d = 1'b1;
            pack_d  = 32'h0000_0000;
            state_d = PAD;
          end else begin
            pack_d = merged;
          end
        end
      end

      // A message ending on a word boundary still owes a standalone 0x80 word.
      PAD: begin
        if (out_hs) begin
          if (full_q) begin
            data_d = 32'h8000_0000;
            full_d = 1'b0;
          end else if (wcnt_inc == 4'd14) begin
            state_d = LEN_HI;
            data_d  = bit_len[63:32];
          end else begin
            state_d = ZERO;
            data_d  = 32'h0000_0000;
          end
        end
      end

      ZERO: begin
        if (out_hs && (wcnt_inc == 4'd14)) begin
          state_d = LEN_HI;
          data_d  = bit_len[63:32];
        end
      end

      LEN_HI: begin
        if (out_hs) begin
          state_d = LEN_LO;
          data_d  = bit_len[31:0];
          last_d  = 1'b1;
        end
      end

      LEN_LO: begin
        if (out_hs) begin
          state_d = ACCEPT;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = 32'h0000_0000;
          bcnt_d  = '0;
          wcnt_d  = 4'd0;
          pack_d  = 32'h0000_0000;
          full_d  = 1'b0;
        end
      end

      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q <= ACCEPT;
      pack_q  <= 32'h0000_0000;
      bcnt_q  <= '0;
      wcnt_q  <= 4'd0;
      full_q  <= 1'b0;
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      full_q  <= full_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages against hand-derived padded words,
// plus output stall stability, input back-pressure and mid-message reset.
module tb_sha256_padder;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_axis_tvalid;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  int errors = 0;
  int checks = 0;

  logic [7:0]  msg [0:63];
  logic [31:0] exp_w [$];
  logic [31:0] got_d [$];
  logic        got_l [$];

  int          last_cnt  = 0;
  int          stall_err = 0;
  int          keep_err  = 0;
  int          rdy_err   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'h0;
  logic        prev_last  = 1'b0;
  logic        tail       = 1'b0;

  sha256_padder #(.LEN_W(32)) dut (
    .m_axis_aclk   (aclk),
    .m_axis_areset (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; everything is observed on the falling edge.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall <= 1'b0;
      tail       <= 1'b0;
    end else begin
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                         m_axis_tlast !== prev_last))
        stall_err <= stall_err + 1;
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_data  <= m_axis_tdata;
      prev_last  <= m_axis_tlast;
      if (m_axis_tkeep !== (m_axis_tvalid ? 4'hF : 4'h0))
        keep_err <= keep_err + 1;
      if (tail && s_axis_tready !== 1'b0)
        rdy_err <= rdy_err + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        if (m_axis_tlast) begin
          tail     <= 1'b0;
          last_cnt <= last_cnt + 1;
        end
      end
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast)
        tail <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input int n);
    exp_w.delete();
    for (int i = 0; i < n; i++) exp_w.push_back(32'h0);
  endtask

  task automatic run_msg(input string name, input int n, input bit toggle);
    int  idx;
    int  cyc;
    int  start_last;
    bit  acc;
    idx        = 0;
    cyc        = 0;
    start_last = last_cnt;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = 4'h3;
    s_axis_tdata  = {24'hA5C3F0, msg[0]};
    s_axis_tlast  = (n == 1);
    while (last_cnt == start_last && cyc < 3000) begin
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) begin
          s_axis_tdata = {24'hA5C3F0, msg[idx]};
          s_axis_tlast = (idx == n - 1);
        end else begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
        end
      end
      if (toggle) m_axis_tready = ~m_axis_tready;
    end
    chk({name, "_done_in_time"}, 32'(cyc < 3000), 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic check_msg(input string name, input int base);
    int n;
    n = got_d.size() - base;
    chk({name, "_count"}, 32'(n), 32'(exp_w.size()));
    for (int i = 0; i < n && i < exp_w.size(); i++) begin
      chk($sformatf("%s_w%0d", name, i), got_d[base + i], exp_w[i]);
      chk($sformatf("%s_last%0d", name, i), 32'(got_l[base + i]), 32'(i == exp_w.size() - 1));
    end
  endtask

  task automatic exp_abc();
    set_exp(16);
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
  endtask

  initial begin
    int base;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = 4'h0;
    s_axis_tdata  = 32'h0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    #3;
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_m_tkeep",  32'(m_axis_tkeep),  32'd0);
    chk("rst_m_tdata",  m_axis_tdata,       32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_release_tready", 32'(s_axis_tready), 32'd1);
    @(posedge aclk);
    #1;

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    base = got_d.size();
    run_msg("abc", 3, 1'b0);
    exp_abc();
    check_msg("abc", base);

    // "adios"
    msg[0] = 8'h61; msg[1] = 8'h64; msg[2] = 8'h69; msg[3] = 8'h6f; msg[4] = 8'h73;
    base = got_d.size();
    run_msg("adios", 5, 1'b0);
    set_exp(16);
    exp_w[0]  = 32'h6164_696f;
    exp_w[1]  = 32'h7380_0000;
    exp_w[15] = 32'h0000_0028;
    check_msg("adios", base);

    // four bytes ending on a word boundary
    msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03; msg[3] = 8'h04;
    base = got_d.size();
    run_msg("four", 4, 1'b0);
    set_exp(16);
    exp_w[0]  = 32'h0102_0304;
    exp_w[1]  = 32'h8000_0000;
    exp_w[15] = 32'h0000_0020;
    check_msg("four", base);

    // 56 bytes 0x00..0x37: the 0x80 word lands at index 14, forcing a second block
    for (int i = 0; i < 56; i++) msg[i] = 8'(i);
    base = got_d.size();
    run_msg("m56", 56, 1'b0);
    set_exp(32);
    for (int k = 0; k < 14; k++)
      exp_w[k] = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
    exp_w[14] = 32'h8000_0000;
    exp_w[31] = 32'h0000_01C0;
    check_msg("m56", base);

    // "abc" with downstream ready toggling every cycle
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    base = got_d.size();
    run_msg("abc_stall", 3, 1'b1);
    exp_abc();
    check_msg("abc_stall", base);

    // Two bytes of a message, then reset, then "abc"
    base = got_d.size();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0000_0011;
    @(posedge aclk);
    #1;
    s_axis_tdata  = 32'h0000_0022;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    chk("abort_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_rst_tready", 32'(s_axis_tready), 32'd0);
    @(posedge aclk);
    #1;
    chk("abort_rst_tvalid_hold", 32'(m_axis_tvalid), 32'd0);
    chk("abort_rst_tdata", m_axis_tdata, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("abort_release_tready", 32'(s_axis_tready), 32'd1);
    chk("abort_no_words", 32'(got_d.size() - base), 32'd0);
    @(posedge aclk);
    #1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    base = got_d.size();
    run_msg("abc_after_rst", 3, 1'b0);
    exp_abc();
    check_msg("abc_after_rst", base);

    chk("stall_stability_violations", 32'(stall_err), 32'd0);
    chk("tkeep_violations",           32'(keep_err),  32'd0);
    chk("s_tready_during_pad",        32'(rdy_err),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
